// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and width constants for the stack-RAM port arbiter.
package ram_arb_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester handshakes and RAM pins of the stack-RAM arbiter.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = ram_arb_pkg::ADDR_W,
   parameter int DATA_W = ram_arb_pkg::DATA_W
);
   logic              req_0, req_1;
   logic              we_0, we_1;
   logic [ADDR_W-1:0] addr_0, addr_1;
   logic [DATA_W-1:0] wdata_0, wdata_1;
   logic              lock_0;
   logic              gnt_0, gnt_1;
   logic              rvalid_0, rvalid_1;
   logic [DATA_W-1:0] rdata_0, rdata_1;
   logic [ADDR_W-1:0] address_ram;
   logic              wren_ram;
   logic [DATA_W-1:0] data_ram;
   logic [DATA_W-1:0] q_ram;

   // Requesters plus the RAM itself sit on the master side.
   modport master (
      output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, lock_0, q_ram,
      input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
             address_ram, wren_ram, data_ram
   );

   modport slave (
      input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, lock_0, q_ram,
      output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
             address_ram, wren_ram, data_ram
   );
endinterface

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Shift register carrying read tags alongside the RAM read latency.
module rd_tag_pipe #(
   parameter int DEPTH = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  ram_arb_pkg::rd_tag_t tag_in,
   output ram_arb_pkg::rd_tag_t tag_out
);
   import ram_arb_pkg::rd_tag_t;

   rd_tag_t stage_reg [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
      end else begin
         stage_reg[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
      end
   end

   assign tag_out = stage_reg[DEPTH-1];
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the single-port stack RAM between CPU and debug reader.
module ram_port_arbiter #(
   parameter int ADDR_W = ram_arb_pkg::ADDR_W,
   parameter int DATA_W = ram_arb_pkg::DATA_W,
   parameter int RD_LAT = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   ram_port_arbiter_if.slave  bus,
   output logic [15:0]        stall_cnt
);
   import ram_arb_pkg::req_id_t;
   import ram_arb_pkg::rd_tag_t;
   import ram_arb_pkg::REQ_CPU;
   import ram_arb_pkg::REQ_DBG;

   req_id_t           ptr_reg, ptr_next;
   logic              gnt_0, gnt_1, any_gnt, sel_we;
   req_id_t           gnt_id;
   logic [ADDR_W-1:0] sel_addr, address_reg;
   logic [DATA_W-1:0] sel_wdata, data_reg, rdata_0_reg, rdata_1_reg;
   logic              wren_reg, rvalid_0_reg, rvalid_1_reg, stall_hit;
   logic [15:0]       stall_cnt_reg;
   rd_tag_t           tag_in, tag_out;

   // Lock only ever suppresses requester 1; it never takes a grant from requester 0.
   always_comb begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
      if (bus.req_0 && bus.req_1) begin
         if (bus.lock_0 || ptr_reg == REQ_CPU) gnt_0 = 1'b1;
         else                                  gnt_1 = 1'b1;
      end else if (bus.req_0) begin
         gnt_0 = 1'b1;
      end else if (bus.req_1 && !bus.lock_0) begin
         gnt_1 = 1'b1;
      end
   end

   always_comb begin
      any_gnt   = gnt_0 | gnt_1;
      gnt_id    = gnt_1 ? REQ_DBG : REQ_CPU;
      sel_addr  = gnt_1 ? bus.addr_1  : bus.addr_0;
      sel_wdata = gnt_1 ? bus.wdata_1 : bus.wdata_0;
      sel_we    = gnt_1 ? bus.we_1    : bus.we_0;
      ptr_next  = ptr_reg;
      if (any_gnt) ptr_next = gnt_1 ? REQ_CPU : REQ_DBG;
      tag_in       = '0;
      tag_in.valid = any_gnt & ~sel_we;
      tag_in.id    = gnt_id;
      stall_hit    = (bus.req_0 & ~gnt_0) | (bus.req_1 & ~gnt_1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) ptr_reg <= REQ_CPU;
      else          ptr_reg <= ptr_next;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         address_reg <= '0;
         data_reg    <= '0;
         wren_reg    <= 1'b0;
      end else begin
         wren_reg <= any_gnt & sel_we;
         if (any_gnt) begin
            address_reg <= sel_addr;
            data_reg    <= sel_wdata;
         end
      end
   end

   rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_0_reg <= 1'b0;
         rvalid_1_reg <= 1'b0;
         rdata_0_reg  <= '0;
         rdata_1_reg  <= '0;
      end else begin
         rvalid_0_reg <= tag_out.valid && tag_out.id == REQ_CPU;
         rvalid_1_reg <= tag_out.valid && tag_out.id == REQ_DBG;
         if (tag_out.valid && tag_out.id == REQ_CPU) rdata_0_reg <= bus.q_ram;
         if (tag_out.valid && tag_out.id == REQ_DBG) rdata_1_reg <= bus.q_ram;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                  stall_cnt_reg <= '0;
      else if (stall_hit && stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'd1;
   end

   assign bus.gnt_0       = gnt_0;
   assign bus.gnt_1       = gnt_1;
   assign bus.address_ram = address_reg;
   assign bus.data_ram    = data_reg;
   assign bus.wren_ram    = wren_reg;
   assign bus.rvalid_0    = rvalid_0_reg;
   assign bus.rvalid_1    = rvalid_1_reg;
   assign bus.rdata_0     = rdata_0_reg;
   assign bus.rdata_1     = rdata_1_reg;
   assign stall_cnt       = stall_cnt_reg;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a two-edge-latency RAM model.
module tb_ram_port_arbiter;
   logic        clock;
   logic        reset_n;
   logic [15:0] stall_cnt;
   int          tests = 0;
   int          fails = 0;

   ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // RAM model: address registered by the arbiter, data registered here.
   logic [15:0] mem [0:255];
   logic [15:0] q_reg;
   logic        loaded = 1'b0;

   function automatic logic [15:0] init_val(input int i);
      case (i)
         5:       return 16'h1234;
         6:       return 16'hA5A5;
         'h10:    return 16'h1010;
         'h20:    return 16'h2020;
         default: return 16'h0A00 | 16'(i);
      endcase
   endfunction

   always @(posedge clock) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         loaded <= 1'b1;
      end else if (bus.wren_ram) begin
         mem[bus.address_ram[7:0]] <= bus.data_ram;
      end
      q_reg <= mem[bus.address_ram[7:0]];
   end
   assign bus.q_ram = q_reg;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      bus.req_0 = r; bus.we_0 = w; bus.addr_0 = a; bus.wdata_0 = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      bus.req_1 = r; bus.we_1 = w; bus.addr_1 = a; bus.wdata_1 = d;
   endtask

   initial begin
      logic [15:0] pipe_exp [4];
      int          k;
      pipe_exp[0] = 16'h0A00; pipe_exp[1] = 16'h0A01; pipe_exp[2] = 16'h0009; pipe_exp[3] = 16'h0A03;

      reset_n = 1'b0;
      bus.lock_0 = 1'b0;
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      tick(); tick();
      check("rst_address_ram", bus.address_ram, 0);
      check("rst_wren_ram", bus.wren_ram, 0);
      check("rst_data_ram", bus.data_ram, 0);
      check("rst_rvalid_0", bus.rvalid_0, 0);
      check("rst_rvalid_1", bus.rvalid_1, 0);
      check("rst_rdata_0", bus.rdata_0, 0);
      check("rst_rdata_1", bus.rdata_1, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      reset_n = 1'b1;

      // Solo read on port 0
      set0(1, 0, 16'h0005, 0);
      #1;
      check("solo0_gnt_0", bus.gnt_0, 1);
      check("solo0_gnt_1", bus.gnt_1, 0);
      tick();
      $display("[TB] txn: port0 read 0x0005");
      set0(0, 0, 0, 0);
      check("solo0_address_ram", bus.address_ram, 16'h0005);
      check("solo0_wren", bus.wren_ram, 0);
      check("solo0_rvalid_early", bus.rvalid_0, 0);
      tick();
      check("solo0_rvalid_t1", bus.rvalid_0, 0);
      check("solo0_addr_hold", bus.address_ram, 16'h0005);
      tick();
      check("solo0_rvalid", bus.rvalid_0, 1);
      check("solo0_rdata", bus.rdata_0, 16'h1234);
      check("solo0_rvalid_1", bus.rvalid_1, 0);
      tick();
      check("solo0_rvalid_drop", bus.rvalid_0, 0);
      check("solo0_rdata_hold", bus.rdata_0, 16'h1234);

      // Solo read on port 1
      set1(1, 0, 16'h0006, 0);
      #1;
      check("solo1_gnt_1", bus.gnt_1, 1);
      check("solo1_gnt_0", bus.gnt_0, 0);
      tick();
      $display("[TB] txn: port1 read 0x0006");
      set1(0, 0, 0, 0);
      check("solo1_address_ram", bus.address_ram, 16'h0006);
      tick();
      check("solo1_rvalid_t1", bus.rvalid_1, 0);
      tick();
      check("solo1_rvalid", bus.rvalid_1, 1);
      check("solo1_rdata", bus.rdata_1, 16'hA5A5);
      check("solo1_rvalid_0", bus.rvalid_0, 0);
      check("solo_stall_cnt", stall_cnt, 0);
      tick();

      // Contention, round robin starting at port 0
      for (int j = 0; j < 8; j++) begin
         set0(j < 4, 0, 16'h0010, 0);
         set1(j < 4, 0, 16'h0020, 0);
         #1;
         check($sformatf("rr_gnt_0[%0d]", j), bus.gnt_0, (j < 4) && (j % 2 == 0));
         check($sformatf("rr_gnt_1[%0d]", j), bus.gnt_1, (j < 4) && (j % 2 == 1));
         check($sformatf("rr_stall[%0d]", j), stall_cnt, (j < 4) ? j : 4);
         k = j - 3;
         check($sformatf("rr_rvalid_0[%0d]", j), bus.rvalid_0, (k >= 0) && (k < 4) && (k % 2 == 0));
         check($sformatf("rr_rvalid_1[%0d]", j), bus.rvalid_1, (k >= 0) && (k < 4) && (k % 2 == 1));
         if (bus.rvalid_0) check($sformatf("rr_rdata_0[%0d]", j), bus.rdata_0, 16'h1010);
         if (bus.rvalid_1) check($sformatf("rr_rdata_1[%0d]", j), bus.rdata_1, 16'h2020);
         if (j < 4) $display("[TB] txn: contention cycle %0d gnt_0=%0b gnt_1=%0b", j, bus.gnt_0, bus.gnt_1);
         tick();
      end

      // Locked CPU sequence: read 3, read 2, write 2 = 9
      bus.lock_0 = 1'b1;
      set1(1, 0, 16'h0030, 0);
      for (int i = 0; i < 3; i++) begin
         set0(1, i == 2, (i == 0) ? 16'h0003 : 16'h0002, (i == 2) ? 16'h0009 : 16'h0000);
         #1;
         check($sformatf("lock_gnt_0[%0d]", i), bus.gnt_0, 1);
         check($sformatf("lock_gnt_1[%0d]", i), bus.gnt_1, 0);
         check($sformatf("lock_wren[%0d]", i), bus.wren_ram, 0);
         $display("[TB] txn: locked cpu op %0d", i);
         tick();
      end
      bus.lock_0 = 1'b0;
      set0(0, 0, 0, 0);
      #1;
      check("unlock_gnt_1", bus.gnt_1, 1);
      check("lock_wren_hi", bus.wren_ram, 1);
      check("lock_wr_addr", bus.address_ram, 16'h0002);
      check("lock_wr_data", bus.data_ram, 16'h0009);
      tick();
      set1(0, 0, 0, 0);
      check("lock_wren_lo", bus.wren_ram, 0);
      check("unlock_addr", bus.address_ram, 16'h0030);
      tick(); tick(); tick();

      // Back-to-back reads on port 1
      for (int j = 0; j < 8; j++) begin
         set1(j < 4, 0, 16'(j), 0);
         #1;
         check($sformatf("pipe_gnt_1[%0d]", j), bus.gnt_1, j < 4);
         check($sformatf("pipe_rvalid_1[%0d]", j), bus.rvalid_1, (j >= 3) && (j < 7));
         check($sformatf("pipe_rvalid_0[%0d]", j), bus.rvalid_0, 0);
         if (j >= 3 && j < 7) check($sformatf("pipe_rdata_1[%0d]", j), bus.rdata_1, pipe_exp[j-3]);
         if (j < 4) $display("[TB] txn: port1 pipelined read 0x%04h", j);
         tick();
      end

      // Write then read of the same address on the next cycle
      for (int j = 0; j < 5; j++) begin
         set0(j < 2, j == 0, 16'h0007, (j == 0) ? 16'hBEEF : 16'h0000);
         #1;
         check($sformatf("wr_gnt_0[%0d]", j), bus.gnt_0, j < 2);
         check($sformatf("wr_wren[%0d]", j), bus.wren_ram, j == 1);
         check($sformatf("wr_rvalid_0[%0d]", j), bus.rvalid_0, j == 4);
         if (j == 4) check("wr_rdata_0", bus.rdata_0, 16'hBEEF);
         if (j < 2) $display("[TB] txn: port0 %s 0x0007", (j == 0) ? "write" : "read");
         tick();
      end

      // Reset one cycle after a read grant, while a write is issuing
      set0(1, 0, 16'h0005, 0);
      #1;
      check("rstmid_gnt_0", bus.gnt_0, 1);
      tick();
      set0(1, 1, 16'h0008, 16'h1111);
      tick();
      set0(0, 0, 0, 0);
      check("rstmid_wren_pre", bus.wren_ram, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rstmid_wren_async", bus.wren_ram, 0);
      check("rstmid_addr_async", bus.address_ram, 0);
      check("rstmid_stall", stall_cnt, 0);
      $display("[TB] txn: reset asserted mid-flight");
      tick();
      reset_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         check($sformatf("rstmid_rvalid_0[%0d]", j), bus.rvalid_0, 0);
         check($sformatf("rstmid_rvalid_1[%0d]", j), bus.rvalid_1, 0);
         tick();
      end
      set0(1, 0, 16'h0010, 0);
      set1(1, 0, 16'h0020, 0);
      #1;
      check("rstmid_rr_gnt_0", bus.gnt_0, 1);
      check("rstmid_rr_gnt_1", bus.gnt_1, 0);
      tick();
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      check("rstmid_stall_one", stall_cnt, 1);

      // Saturation of the stall counter
      bus.lock_0 = 1'b1;
      set1(1, 0, 16'h0020, 0);
      #1;
      check("sat_gnt_1", bus.gnt_1, 0);
      $display("[TB] txn: holding locked-out port1 request for 70000 cycles");
      repeat (70000) tick();
      check("sat_stall_cnt", stall_cnt, 16'hFFFF);
      repeat (3) tick();
      check("sat_stall_hold", stall_cnt, 16'hFFFF);
      bus.lock_0 = 1'b0;
      set1(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
